// File: rtl/decode_bundle_pkg.sv
// Shared types and constants for the decode stage: ALU op codes, MIPS-style
// opcode/funct encodings, the per-lane decoded record and the buffer states.
package decode_pkg;

    localparam int ALU_OP_BITS = 9;
    typedef logic [ALU_OP_BITS-1:0] aluop_t;

    localparam aluop_t ALU_NOP  = 9'd0;
    localparam aluop_t ALU_ADD  = 9'd1;
    localparam aluop_t ALU_ADDU = 9'd2;
    localparam aluop_t ALU_SUB  = 9'd3;
    localparam aluop_t ALU_SUBU = 9'd4;
    localparam aluop_t ALU_AND  = 9'd5;
    localparam aluop_t ALU_OR   = 9'd6;
    localparam aluop_t ALU_XOR  = 9'd7;
    localparam aluop_t ALU_NOR  = 9'd8;
    localparam aluop_t ALU_SLT  = 9'd9;
    localparam aluop_t ALU_SLTU = 9'd10;
    localparam aluop_t ALU_SLL  = 9'd11;
    localparam aluop_t ALU_SRL  = 9'd12;
    localparam aluop_t ALU_SRA  = 9'd13;
    localparam aluop_t ALU_LUI  = 9'd14;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        aluop_t      aluop;
        logic        regw;
        logic        instvalid;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [4:0]  rdst;
        logic [31:0] imm;
    } decoded_lane_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_SKID
    } buf_state_t;

    // Every legal encoding maps to a non-zero op, so ALU_NOP doubles as "illegal".
    function automatic aluop_t funct_to_aluop(input logic [5:0] funct);
        case (funct)
            FN_SLL:  return ALU_SLL;
            FN_SRL:  return ALU_SRL;
            FN_SRA:  return ALU_SRA;
            FN_ADD:  return ALU_ADD;
            FN_ADDU: return ALU_ADDU;
            FN_SUB:  return ALU_SUB;
            FN_SUBU: return ALU_SUBU;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_XOR:  return ALU_XOR;
            FN_NOR:  return ALU_NOR;
            FN_SLT:  return ALU_SLT;
            FN_SLTU: return ALU_SLTU;
            default: return ALU_NOP;
        endcase
    endfunction

    function automatic aluop_t opcode_to_aluop(input logic [5:0] opcode);
        case (opcode)
            OP_ADDI:  return ALU_ADD;
            OP_ADDIU: return ALU_ADDU;
            OP_SLTI:  return ALU_SLT;
            OP_SLTIU: return ALU_SLTU;
            OP_ANDI:  return ALU_AND;
            OP_ORI:   return ALU_OR;
            OP_XORI:  return ALU_XOR;
            OP_LUI:   return ALU_LUI;
            default:  return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/decode_bundle_if.sv
// Bundle handshake between fetch queue (master) and the decode stage (slave),
// plus the decoded output bundle towards rename/dispatch.
interface decode_bundle_if #(
    parameter int WIDTH   = 4,
    parameter int ALUOP_W = 9
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH*32-1:0]      in_inst;
    logic [WIDTH-1:0]         in_mask;

    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_mask;
    logic [CNT_W-1:0]         out_count;
    logic [WIDTH*ALUOP_W-1:0] out_aluop;
    logic [WIDTH-1:0]         out_regw;
    logic [WIDTH-1:0]         out_instvalid;
    logic [WIDTH*5-1:0]       out_src1;
    logic [WIDTH*5-1:0]       out_src2;
    logic [WIDTH*5-1:0]       out_rdst;
    logic [WIDTH*32-1:0]      out_imm;

    modport master (
        output in_valid, in_inst, in_mask, out_ready,
        input  in_ready, out_valid, out_mask, out_count, out_aluop, out_regw,
               out_instvalid, out_src1, out_src2, out_rdst, out_imm
    );

    modport slave (
        input  in_valid, in_inst, in_mask, out_ready,
        output in_ready, out_valid, out_mask, out_count, out_aluop, out_regw,
               out_instvalid, out_src1, out_src2, out_rdst, out_imm
    );

endinterface

// File: rtl/decode_bundle_lane.sv
// Combinational single-instruction decoder; an unoccupied lane yields all zeros.
module decode_lane
    import decode_pkg::*;
(
    input  logic          occupied,
    input  logic [31:0]   inst,
    output decoded_lane_t dec
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = inst[31:26];
    assign funct  = inst[5:0];

    always_comb begin
        // NOTE: assign every combinational output a default first so no path leaves it unassigned and infers a latch.
        dec = '0;
        if (occupied) begin
            dec.src1 = inst[25:21];
            dec.src2 = inst[20:16];
            dec.imm  = {{16{inst[15]}}, inst[15:0]};
            if (opcode == OP_RTYPE) begin
                dec.rdst  = inst[15:11];
                dec.aluop = funct_to_aluop(funct);
            end else begin
                dec.rdst  = inst[20:16];
                dec.aluop = opcode_to_aluop(opcode);
            end
            dec.instvalid = (dec.aluop != ALU_NOP);
            dec.regw      = dec.instvalid & (dec.rdst != 5'd0);
        end
    end

endmodule

// File: rtl/decode_bundle.sv
// N-wide decode stage with a 2-entry skid buffer and registered in_ready.
// Define DECODE_COMPACT_EN to pack occupied slots into lanes 0..k-1.
module decode_bundle
    import decode_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int ALUOP_W = 9
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    decode_bundle_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef struct packed {
        decoded_lane_t [WIDTH-1:0] lane;
        logic [WIDTH-1:0]          mask;
        logic [CNT_W-1:0]          count;
    } bundle_t;

    logic [WIDTH-1:0]            occ;
    decoded_lane_t [WIDTH-1:0]   dec;
    logic [WIDTH-1:0][CNT_W-1:0] prefix;
    bundle_t                     incoming;

    buf_state_t state_q, state_d;
    bundle_t    main_q, main_d;
    bundle_t    skid_q, skid_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid;
    logic       accept;
    logic       rel;

    assign occ = bus.in_mask & {WIDTH{bus.in_valid}};

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        decode_lane u_lane (
            .occupied (occ[g]),
            .inst     (bus.in_inst[32*g +: 32]),
            .dec      (dec[g])
        );
    end

    // prefix[i] counts occupied slots below slot i; it is both the compaction
    // target lane and the running popcount.
    always_comb begin
        incoming = '0;
        prefix   = '0;
        for (int i = 1; i < WIDTH; i++) begin
            prefix[i] = prefix[i-1] + CNT_W'(occ[i-1]);
        end
        incoming.count = prefix[WIDTH-1] + CNT_W'(occ[WIDTH-1]);
`ifdef DECODE_COMPACT_EN
        for (int j = 0; j < WIDTH; j++) begin
            incoming.mask[j] = (CNT_W'(j) < incoming.count);
            for (int i = 0; i < WIDTH; i++) begin
                if (occ[i] && (prefix[i] == CNT_W'(j))) begin
                    incoming.lane[j] = dec[i];
                end
            end
        end
`else
        incoming.mask = occ;
        incoming.lane = dec;
`endif
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = bus.in_valid & in_ready_q & ~flush;
    assign rel       = out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_FULL;
                        main_d  = incoming;
                    end
                end
                ST_FULL: begin
                    if (accept && rel) begin
                        main_d = incoming;
                    end else if (accept) begin
                        skid_d  = incoming;
                        state_d = ST_SKID;
                    end else if (rel) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (rel) begin
                        main_d  = skid_q;
                        state_d = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        // Registered from the next state so out_ready never reaches in_ready combinationally.
        in_ready_d = (state_d != ST_SKID);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            // NOTE: the skid register is only read after a write, but resetting it keeps every flop defined after reset.
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.out_mask  = main_q.mask;
    assign bus.out_count = main_q.count;

    for (genvar g = 0; g < WIDTH; g++) begin : g_out
        assign bus.out_aluop[g*ALUOP_W +: ALUOP_W] = ALUOP_W'(main_q.lane[g].aluop);
        assign bus.out_regw[g]                     = main_q.lane[g].regw;
        assign bus.out_instvalid[g]                = main_q.lane[g].instvalid;
        assign bus.out_src1[5*g +: 5]              = main_q.lane[g].src1;
        assign bus.out_src2[5*g +: 5]              = main_q.lane[g].src2;
        assign bus.out_rdst[5*g +: 5]              = main_q.lane[g].rdst;
        assign bus.out_imm[32*g +: 32]             = main_q.lane[g].imm;
    end

endmodule

// File: tb/tb_decode_bundle.sv
// Self-checking bench for decode_bundle: a queue-based reference of the stage
// checked every cycle, plus hand-computed literal expectations.
module tb_decode_bundle;
    import decode_pkg::*;

    localparam int W  = 4;
    localparam int AW = 9;
    localparam int CW = $clog2(W + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    decode_bundle_if #(.WIDTH(W), .ALUOP_W(AW)) bus ();

    decode_bundle #(.WIDTH(W), .ALUOP_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: the stage is a queue of at most two decoded bundles.
    typedef struct {
        logic [W-1:0]    mask;
        logic [CW-1:0]   count;
        logic [W*AW-1:0] aluop;
        logic [W-1:0]    regw;
        logic [W-1:0]    iv;
        logic [W*5-1:0]  s1;
        logic [W*5-1:0]  s2;
        logic [W*5-1:0]  rd;
        logic [W*32-1:0] imm;
    } exp_t;

    exp_t q[$];
    bit   live = 1'b0;

    function automatic aluop_t ref_op(input logic [31:0] x);
        if (x[31:26] == 6'd0) begin
            case (x[5:0])
                6'h00: return ALU_SLL;
                6'h02: return ALU_SRL;
                6'h03: return ALU_SRA;
                6'h20: return ALU_ADD;
                6'h21: return ALU_ADDU;
                6'h22: return ALU_SUB;
                6'h23: return ALU_SUBU;
                6'h24: return ALU_AND;
                6'h25: return ALU_OR;
                6'h26: return ALU_XOR;
                6'h27: return ALU_NOR;
                6'h2A: return ALU_SLT;
                6'h2B: return ALU_SLTU;
                default: return ALU_NOP;
            endcase
        end
        case (x[31:26])
            6'h08: return ALU_ADD;
            6'h09: return ALU_ADDU;
            6'h0A: return ALU_SLT;
            6'h0B: return ALU_SLTU;
            6'h0C: return ALU_AND;
            6'h0D: return ALU_OR;
            6'h0E: return ALU_XOR;
            6'h0F: return ALU_LUI;
            default: return ALU_NOP;
        endcase
    endfunction

    function automatic exp_t model_bundle(input logic [W*32-1:0] inst, input logic [W-1:0] mask);
        exp_t        e;
        int          k;
        int          lane;
        logic [31:0] x;
        aluop_t      op;
        logic [4:0]  rdst;
        e = '{default: '0};
        k = 0;
        for (int i = 0; i < W; i++) begin
            if (mask[i]) begin
`ifdef DECODE_COMPACT_EN
                lane = k;
`else
                lane = i;
`endif
                x    = inst[32*i +: 32];
                op   = ref_op(x);
                rdst = (x[31:26] == 6'd0) ? x[15:11] : x[20:16];
                e.mask[lane]            = 1'b1;
                e.aluop[AW*lane +: AW]  = op;
                e.iv[lane]              = (op != ALU_NOP);
                e.regw[lane]            = (op != ALU_NOP) && (rdst != 5'd0);
                e.s1[5*lane +: 5]       = x[25:21];
                e.s2[5*lane +: 5]       = x[20:16];
                e.rd[5*lane +: 5]       = rdst;
                e.imm[32*lane +: 32]    = {{16{x[15]}}, x[15:0]};
                k++;
            end
        end
        e.count = CW'(k);
        return e;
    endfunction

    // Compare on the falling edge, then advance the reference to the next rising edge.
    initial begin
        exp_t e;
        bit   acc;
        bit   rls;
        forever begin
            @(negedge clk);
            if (live) begin
                check("in_ready", bus.in_ready, q.size() < 2);
                check("out_valid", bus.out_valid, q.size() > 0);
                if (q.size() > 0) begin
                    e = q[0];
                    check("out_mask", bus.out_mask, e.mask);
                    check("out_count", bus.out_count, e.count);
                    check("out_aluop", bus.out_aluop, e.aluop);
                    check("out_regw", bus.out_regw, e.regw);
                    check("out_instvalid", bus.out_instvalid, e.iv);
                    check("out_src1", bus.out_src1, e.s1);
                    check("out_src2", bus.out_src2, e.s2);
                    check("out_rdst", bus.out_rdst, e.rd);
                    check("out_imm", bus.out_imm, e.imm);
                end
            end
            if (!rst_n) begin
                q.delete();
                live = 1'b1;
            end else if (live) begin
                acc = bus.in_valid && (q.size() < 2) && !flush;
                rls = (q.size() > 0) && bus.out_ready;
                if (flush) begin
                    q.delete();
                end else begin
                    if (rls) void'(q.pop_front());
                    if (acc) q.push_back(model_bundle(bus.in_inst, bus.in_mask));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W*32-1:0] inst, input logic [W-1:0] mask);
        bus.in_valid = v;
        bus.in_inst  = inst;
        bus.in_mask  = mask;
    endtask

    logic [31:0] pool [8] = '{32'h00221820, 32'h2062FFFC, 32'hFC000000, 32'h00A63822,
                              32'h34048001, 32'h00000000, 32'h3C01ABCD, 32'h0022182F};
    logic [15:0] rdy_pat = 16'b1011_0010_1101_0110;
    logic [15:0] val_pat = 16'b1110_1111_0111_1011;

    initial begin
        logic [W*32-1:0] inst;
        bus.out_ready = 1'b1;
        drive(1'b0, '0, '0);
        step();
        step();
        rst_n = 1'b1;
        check("reset in_ready", bus.in_ready, 1'b1);
        check("reset out_valid", bus.out_valid, 1'b0);
        check("reset out_mask", bus.out_mask, '0);
        check("reset out_count", bus.out_count, '0);

        // add $3,$1,$2 in slot 0
        drive(1'b1, {96'h0, 32'h00221820}, 4'b0001);
        step();
        check("add out_valid", bus.out_valid, 1'b1);
        check("add src1", bus.out_src1[4:0], 5'd1);
        check("add src2", bus.out_src2[4:0], 5'd2);
        check("add rdst", bus.out_rdst[4:0], 5'd3);
        check("add regw", bus.out_regw[0], 1'b1);
        check("add instvalid", bus.out_instvalid[0], 1'b1);
        check("add aluop", bus.out_aluop[AW-1:0], ALU_ADD);
        check("add count", bus.out_count, 3'd1);
        check("add in_ready", bus.in_ready, 1'b1);

        // addi $2,$3,-4 in slot 0, illegal opcode in slot 1
        drive(1'b1, {64'h0, 32'hFC000000, 32'h2062FFFC}, 4'b0011);
        step();
        check("addi rdst", bus.out_rdst[4:0], 5'd2);
        check("addi imm", bus.out_imm[31:0], 32'hFFFFFFFC);
        check("illegal instvalid", bus.out_instvalid, 4'b0001);
        check("illegal regw", bus.out_regw[1], 1'b0);
        check("illegal aluop", bus.out_aluop[2*AW-1:AW], '0);

        // sub $7,$5,$6 in slot 1, ori $4,$0,0x8001 in slot 3
        drive(1'b1, {32'h34048001, 32'h00221820, 32'h00A63822, 32'h00221820}, 4'b1010);
        step();
        check("sparse count", bus.out_count, 3'd2);
`ifdef DECODE_COMPACT_EN
        check("compact mask", bus.out_mask, 4'b0011);
        check("compact lane0 rdst", bus.out_rdst[4:0], 5'd7);
        check("compact lane1 rdst", bus.out_rdst[9:5], 5'd4);
        check("compact lane1 imm", bus.out_imm[63:32], 32'hFFFF8001);
`else
        check("positional mask", bus.out_mask, 4'b1010);
        check("positional lane1 rdst", bus.out_rdst[9:5], 5'd7);
        check("positional lane3 rdst", bus.out_rdst[19:15], 5'd4);
        check("positional lane3 imm", bus.out_imm[127:96], 32'hFFFF8001);
`endif
        drive(1'b0, '0, '0);
        step();

        // Backpressure: B0 main, B1 skid, B2 held off
        bus.out_ready = 1'b0;
        drive(1'b1, {96'h0, 32'h20210001}, 4'b0001);
        step();
        check("bp B0 in_ready", bus.in_ready, 1'b1);
        drive(1'b1, {96'h0, 32'h20420002}, 4'b0001);
        step();
        check("bp skid in_ready", bus.in_ready, 1'b0);
        check("bp head B0", bus.out_src1[4:0], 5'd1);
        drive(1'b1, {96'h0, 32'h20630003}, 4'b0001);
        step();
        check("bp hold in_ready", bus.in_ready, 1'b0);
        check("bp hold head B0", bus.out_src1[4:0], 5'd1);
        bus.out_ready = 1'b1;
        step();
        check("bp head B1", bus.out_src1[4:0], 5'd2);
        check("bp reopen in_ready", bus.in_ready, 1'b1);
        step();
        check("bp head B2", bus.out_src1[4:0], 5'd3);
        drive(1'b0, '0, '0);
        step();
        check("bp drained", bus.out_valid, 1'b0);

        // Flush while in SKID with a bundle presented the same cycle
        bus.out_ready = 1'b0;
        drive(1'b1, {96'h0, 32'h20210001}, 4'b0001);
        step();
        drive(1'b1, {96'h0, 32'h20420002}, 4'b0001);
        step();
        drive(1'b1, {96'h0, 32'h20630003}, 4'b0001);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush out_valid", bus.out_valid, 1'b0);
        check("flush in_ready", bus.in_ready, 1'b1);
        drive(1'b0, '0, '0);
        step();
        check("flush no ghost", bus.out_valid, 1'b0);

        // Flush coinciding with release and a presented bundle
        bus.out_ready = 1'b1;
        drive(1'b1, {96'h0, 32'h20210001}, 4'b0001);
        step();
        drive(1'b1, {96'h0, 32'h20420002}, 4'b0001);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush+release out_valid", bus.out_valid, 1'b0);

        // Empty-mask bundle is still a bundle
        drive(1'b1, {4{32'h00221820}}, 4'b0000);
        step();
        check("empty out_valid", bus.out_valid, 1'b1);
        check("empty count", bus.out_count, '0);
        check("empty mask", bus.out_mask, '0);

        // Reset while FULL with out_ready low
        bus.out_ready = 1'b0;
        drive(1'b1, {4{32'h00221820}}, 4'b1111);
        step();
        drive(1'b1, {4{32'h2062FFFC}}, 4'b1111);
        rst_n = 1'b0;
        step();
        check("midreset out_valid", bus.out_valid, 1'b0);
        check("midreset in_ready", bus.in_ready, 1'b1);
        check("midreset mask", bus.out_mask, '0);
        check("midreset count", bus.out_count, '0);
        check("midreset fields", {bus.out_aluop, bus.out_regw, bus.out_instvalid, bus.out_src1, bus.out_src2, bus.out_rdst}, '0);
        check("midreset imm", bus.out_imm, '0);
        rst_n = 1'b1;
        drive(1'b0, '0, '0);
        step();

        // Streaming: full throughput, then mixed valid/ready patterns
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            for (int s = 0; s < W; s++) inst[32*s +: 32] = pool[(c + 3*s) % 8];
            if (c >= 16) bus.out_ready = rdy_pat[c % 16];
            drive((c < 16) ? 1'b1 : val_pat[c % 16], inst, 4'((c * 5 + 3) % 16));
            step();
        end
        bus.out_ready = 1'b1;
        drive(1'b0, '0, '0);
        step();
        step();
        step();
        check("final drained", bus.out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_bundle.md
# decode_bundle

Parametrised N-wide decode stage between the fetch-bundle queue and rename/dispatch. Each cycle it accepts one bundle of `WIDTH` instructions with a per-slot mask and decodes every occupied slot. It registers the decoded fields behind a valid/ready handshake with a 2-entry skid buffer, so `in_ready` is a registered signal. A flush input clears the stage.

## Interface
Parameters:
- `WIDTH`, 4: instruction slots per bundle (1..8)
- `ALUOP_W`, 9: ALU operation code width

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous active-low reset
- `flush`  in  1  discard all held and incoming bundles
- `in_valid`  in  1  bundle present
- `in_ready`  out  1  stage can accept a bundle
- `in_inst`  in  WIDTH*32  instructions; slot i = bits [32i+31:32i]
- `in_mask`  in  WIDTH  slot i occupied
- `out_valid`  out  1  decoded bundle present
- `out_ready`  in  1  consumer accepts
- `out_mask`  out  WIDTH  output lane occupied
- `out_count`  out  $clog2(WIDTH+1)  popcount of `out_mask`
- `out_aluop`  out  WIDTH*ALUOP_W  per-lane ALU op
- `out_regw`  out  WIDTH  per-lane register write
- `out_instvalid`  out  WIDTH  lane holds a legal opcode
- `out_src1`, `out_src2`, `out_rdst`  out  WIDTH*5 each  register specifiers
- `out_imm`  out  WIDTH*32  sign-extended imm16

## Operation
- Lane decode, gated by `in_valid & in_mask[i]`:
  - src1 = inst[25:21], src2 = inst[20:16].
  - opcode inst[31:26] == 0: R-type. rdst = inst[15:11]; ALU op from funct inst[5:0].
  - Otherwise: I-type. rdst = inst[20:16].
  - imm = {16{inst[15]}, inst[15:0]}.
  - regw = instvalid & (rdst != 0).
  - Unknown opcode/funct: instvalid = 0, regw = 0, aluop = `ALU_NOP`.
  - Unoccupied lane: every field is 0.
- Acceptance: `in_valid & in_ready`. Release: `out_valid & out_ready`.
- Buffer FSM:
  - EMPTY → FULL on accept.
  - FULL → SKID on accept without release.
  - FULL → EMPTY on release without accept.
  - FULL → FULL on accept with release.
  - SKID → FULL on release; skid contents move to the main register.
  - SKID never accepts.
- `in_ready` = (state != SKID), registered. `out_valid` = (state != EMPTY).
- Output fields are driven from the main register only. Bundle order is preserved.
- An accepted bundle with `in_mask` == 0 is still a bundle: `out_valid` = 1, `out_count` = 0.
- `flush`: next state is EMPTY; the input is not accepted that cycle; `in_ready` = 1 the next cycle. `flush` has priority over simultaneous accept and release. A release coinciding with `flush` still counts for the consumer.
- Reset: state EMPTY; all output registers, `out_mask` and `out_count` are 0; `out_valid` = 0; `in_ready` = 1 on the first cycle after reset deasserts. Reset mid-handshake drops all held bundles.

## Timing
- Latency: 1 cycle from acceptance to `out_valid`, when EMPTY or releasing.
- Throughput: 1 bundle/cycle while `out_ready` is held high.
- Backpressure: one extra bundle is absorbed in the skid; `in_ready` falls the cycle after the skid fills.
- No combinational path from `out_ready` to `in_ready`.

## Configuration
- `DECODE_COMPACT_EN` defined: occupied slots are packed in slot order into lanes 0..k-1 before registering. `out_mask` = (1<<k)-1. Packing uses a prefix-count mux, in the same cycle, with no extra latency.
- Undefined: lanes are positional; `out_mask` = accepted `in_mask`.
- `out_count` = popcount in both builds.

## Structure
- Package `decode_pkg` holds:
  - `ALU_*` localparams of width ALUOP_W, including `ALU_NOP` = 0
  - opcode/funct constants
  - the `decoded_lane_t` struct: aluop, regw, instvalid, src1, src2, rdst, imm
- Sub-module `decode_lane`: purely combinational single-instruction decoder, instantiated `WIDTH` times via generate.
- Buffer FSM, compaction logic and popcount live in `decode_bundle`.

## Test plan
- Reset, then one bundle: slot0 = 0x00221820 (add $3,$1,$2), mask 0001, `out_ready` = 1. Next cycle: `out_valid` = 1; lane0 src1 = 1, src2 = 2, rdst = 3, regw = 1, instvalid = 1; `out_count` = 1; `in_ready` = 1 throughout.
- I-type 0x2062FFFC (addi $2,$3,-4): lane rdst = 2, imm = 0xFFFFFFFC. Illegal opcode 0xFC000000: instvalid = 0, regw = 0, aluop = 0.
- `out_ready` = 0, stream 3 bundles B0, B1, B2: B0 in main, B1 in skid, `in_ready` = 0 from cycle 3, B2 held off. Raise `out_ready`: B0, B1, B2 released in order, one per cycle.
- `flush` while in SKID, with `in_valid` = 1 on the same cycle: next cycle `out_valid` = 0 and `in_ready` = 1; the flushed-cycle bundle never appears.
- Mask 1010, WIDTH = 4: with `DECODE_COMPACT_EN`, slot1 → lane0, slot3 → lane1, `out_mask` = 0011. Without it, `out_mask` = 1010. `out_count` = 2 in both.
- Reset asserted while FULL with `out_ready` = 0: next cycle `out_valid` = 0, all fields 0, `in_ready` = 1.
